vga_scene_renderer: RTL and testbench
=====================================

Name: vga_scene_renderer

Overview:
- Parametrised successor to the fixed 640x480 timing and bird renderer. It generates VGA sync and draws the bird sprite plus NUM_PIPES pipe obstacles over the sky background, at configurable colour depth.
- Scene inputs are latched once per frame to avoid tearing. A frame_tick pulse tells game logic when to update.
- Sits between the game-state FSM and the VGA connector, clocked by the 25 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse length
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse length
- V_BP, 29, vertical back porch
- COLOR_W, 3, bits per colour channel
- BIRD_X, 200, bird left edge, in active-area pixels
- BIRD_SIZE, 20, bird square side
- NUM_PIPES, 2, number of pipe channels
- PIPE_W, 40, pipe width
- GAP_H, 100, vertical opening in each pipe

Ports:
- dclk  in  1  pixel clock
- clr  in  1  synchronous active-high reset
- bird_y  in  9  bird top edge, in active-area lines
- pipe_x  in  NUM_PIPES*10  packed pipe left edges; pipe i is bits [10i+9:10i]
- pipe_gap_y  in  NUM_PIPES*9  packed gap top edges; pipe i is bits [9i+8:9i]
- game_state  in  1  1 = playing, 0 = game over
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- red, green, blue  out  COLOR_W each  pixel colour
- active  out  1  high while in the visible area
- frame_tick  out  1  one-cycle pulse at the end of active video

Behaviour:
- Reset is synchronous: clr is sampled on the dclk rising edge. Its polarity and synchronicity are fixed.
- Line and frame totals:
  - H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP (800 by default).
  - V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP (521 by default).
- Counters hc and vc (11 bits each) count from 0.
  - hc wraps at H_TOTAL-1.
  - vc increments on each hc wrap and wraps at V_TOTAL-1.
  - Phase order within each period: sync, back porch, active, front porch. Count 0 is the first sync cycle.
- Active-area coordinates: ax = hc - (H_SYNC+H_BP), ay = vc - (V_SYNC+V_BP). The visible area is 0 <= ax < H_ACTIVE and 0 <= ay < V_ACTIVE.
- Output pipeline: one registered stage. Sync, colour and active for counter state (hc, vc) all appear together on the next dclk edge. Latency is exactly 1 cycle, with sync and colour aligned.
- Shadow registers:
  - bird_y, pipe_x and pipe_gap_y load into shadow registers only on the cycle frame_tick is asserted.
  - Rendering uses only the shadow copies.
  - game_state is used live, not shadowed.
- frame_tick is a registered pulse of exactly 1 cycle per frame. It fires for counter state hc = H_TOTAL-1, vc = V_SYNC+V_BP+V_ACTIVE-1, i.e. on the last pixel of the last active line.
- Colour priority in the visible area: bird, then pipe, then sky.
  - Bird: ax in [BIRD_X, BIRD_X+BIRD_SIZE) and ay in [bird_y, bird_y+BIRD_SIZE).
  - Pipe i: ax in [pipe_x_i, pipe_x_i+PIPE_W) and (ay < gap_y_i or ay >= gap_y_i+GAP_H).
  - All comparisons use 11-bit zero-extended arithmetic, so right edges never wrap.
  - A pipe or bird with its left edge >= H_ACTIVE (or top edge >= V_ACTIVE) is invisible. Objects that run off the right or bottom edge are clipped.
- Colours, with ONES = all bits 1 and MSB = only the top bit set:
  - Sky: red 0, green MSB, blue ONES.
  - Pipe: red 0, green ONES, blue 0.
  - Bird while playing: red ONES, green ONES, blue 0.
  - Bird at game over (game_state = 0): red ONES, green 0, blue 0.
  - Outside the visible area: colour is 0.
- Reset values:
  - hc, vc = 0; hsync, vsync = 1; rgb = 0; active = 0; frame_tick = 0.
  - Shadow bird_y = 0, shadow pipe_x = 10'h3FF (off-screen), shadow gap_y = 0.
- Reset mid-frame: counters, outputs and shadows return to their reset values on the same edge. hsync goes to 0 on the edge after clr deasserts.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - An extra input port test_mode (1 bit) exists.
  - While test_mode = 1, the visible area shows 8 vertical bars, each H_ACTIVE/8 wide, coloured from ax[9:7]-style bar index b (0..7): red = b[2] ? ONES : 0, green = b[1] ? ONES : 0, blue = b[0] ? ONES : 0.
  - Timing, latency and frame_tick are unchanged.
- When undefined: the port is absent and only the scene renders.

Test Plan:
- Hold clr for 3 cycles, then release → first hsync low window is 96 cycles long, line period is 800, vsync low for 2 lines (1600 cycles), frame period is 416800 cycles.
- Free run → frame_tick pulses exactly once per 416800 cycles. The pulse is 1 cycle wide and lands at hc=799, vc=510.
- bird_y=100, pipes off-screen → output pixel (ax=200..219, ay=100..119) is yellow (7,7,0). Pixel (220,100) is sky (0,4,7).
- pipe0 x=300, gap_y=150; pipe1 x=630 → ax=300..339 is green except ay 150..249. Pipe1 is drawn only at ax 630..639, with no wrap at ax 0..29.
- Change bird_y mid-frame from 100 to 300 → the current frame still draws the bird at 100. The next frame draws it at 300.
- game_state=0 with the bird visible → bird pixels are (7,0,0), sky and pipes unchanged. With VGA_TEST_PATTERN_EN and test_mode=1: ax=0 gives (0,0,0), ax=560 gives (7,7,7).

Source files
------------

// File: rtl/vga_scene_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scene_renderer
//  Purpose  : VGA timing generator and scene renderer for a bird sprite, pipes
//             and sky. Scene inputs are shadowed once per frame. The optional
//             bar test pattern is enabled by defining VGA_TEST_PATTERN_EN.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module vga_scene_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 29,
    parameter int COLOR_W   = 3,
    parameter int BIRD_X    = 200,
    parameter int BIRD_SIZE = 20,
    parameter int NUM_PIPES = 2,
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 100
) (
    input  logic                   dclk,
    input  logic                   clr,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                   test_mode,
`endif
    input  logic [8:0]             bird_y,
    input  logic [NUM_PIPES*10-1:0] pipe_x,
    input  logic [NUM_PIPES*9-1:0] pipe_gap_y,
    input  logic                   game_state,
    output logic                   hsync,
    output logic                   vsync,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   active,
    output logic                   frame_tick
);

    localparam logic [10:0] c_H_LAST   = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [10:0] c_V_LAST   = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [10:0] c_H_SYNC   = 11'(H_SYNC);
    localparam logic [10:0] c_V_SYNC   = 11'(V_SYNC);
    localparam logic [10:0] c_H_START  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] c_V_START  = 11'(V_SYNC + V_BP);
    localparam logic [10:0] c_H_END    = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] c_V_END    = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] c_TICK_V   = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] c_BIRD_L   = 11'(BIRD_X);
    localparam logic [10:0] c_BIRD_R   = 11'(BIRD_X + BIRD_SIZE);
    localparam logic [10:0] c_BIRD_SZ  = 11'(BIRD_SIZE);
    localparam logic [10:0] c_PIPE_W   = 11'(PIPE_W);
    localparam logic [10:0] c_GAP_H    = 11'(GAP_H);
    localparam logic [COLOR_W-1:0] c_ONES = '1;
    localparam logic [COLOR_W-1:0] c_MSB  = COLOR_W'(1 << (COLOR_W - 1));

    logic [10:0]               r_hc;
    logic [10:0]               r_vc;
    logic [8:0]                r_bird_y;
    logic [NUM_PIPES*10-1:0]   r_pipe_x;
    logic [NUM_PIPES*9-1:0]    r_gap_y;
    logic                      r_hsync;
    logic                      r_vsync;
    logic                      r_active;
    logic                      r_frame_tick;
    logic [COLOR_W-1:0]        r_red;
    logic [COLOR_W-1:0]        r_green;
    logic [COLOR_W-1:0]        r_blue;

    logic [10:0]               w_ax;
    logic [10:0]               w_ay;
    logic [10:0]               w_by;
    logic                      w_visible;
    logic                      w_bird_hit;
    logic [NUM_PIPES-1:0]      w_pipe_hit;
    logic                      w_tick;
    logic [COLOR_W-1:0]        w_red;
    logic [COLOR_W-1:0]        w_green;
    logic [COLOR_W-1:0]        w_blue;

    always_ff @(posedge dclk) begin
        if (clr) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == c_H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == c_V_LAST) ? '0 : r_vc + 11'd1;
        end else begin
            r_hc <= r_hc + 11'd1;
        end
    end

    // Shadow copies change only between frames so a frame never tears.
    always_ff @(posedge dclk) begin
        if (clr) begin
            r_bird_y <= '0;
            r_pipe_x <= {NUM_PIPES{10'h3FF}};
            r_gap_y  <= '0;
        end else if (r_frame_tick) begin
            r_bird_y <= bird_y;
            r_pipe_x <= pipe_x;
            r_gap_y  <= pipe_gap_y;
        end
    end

    // Outside the visible window these wrap to large values; all hits are gated by w_visible.
    assign w_ax      = r_hc - c_H_START;
    assign w_ay      = r_vc - c_V_START;
    assign w_by      = {2'b00, r_bird_y};
    assign w_visible = (r_hc >= c_H_START) && (r_hc < c_H_END) &&
                       (r_vc >= c_V_START) && (r_vc < c_V_END);
    assign w_tick    = (r_hc == c_H_LAST) && (r_vc == c_TICK_V);

    assign w_bird_hit = (w_ax >= c_BIRD_L) && (w_ax < c_BIRD_R) &&
                        (w_ay >= w_by) && (w_ay < w_by + c_BIRD_SZ);

    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
        logic [10:0] w_px;
        logic [10:0] w_gy;
        assign w_px = {1'b0, r_pipe_x[10*gi +: 10]};
        assign w_gy = {2'b00, r_gap_y[9*gi +: 9]};
        assign w_pipe_hit[gi] = (w_ax >= w_px) && (w_ax < w_px + c_PIPE_W) &&
                                ((w_ay < w_gy) || (w_ay >= w_gy + c_GAP_H));
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_BAR_W = H_ACTIVE / 8;
    logic [2:0] w_bar;

    always_comb begin
        w_bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (w_ax >= 11'(k * c_BAR_W)) w_bar = 3'(k);
        end
    end
`endif

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (w_visible) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) begin
                w_red   = w_bar[2] ? c_ONES : '0;
                w_green = w_bar[1] ? c_ONES : '0;
                w_blue  = w_bar[0] ? c_ONES : '0;
            end else
`endif
            if (w_bird_hit) begin
                w_red   = c_ONES;
                w_green = game_state ? c_ONES : '0;
            end else if (|w_pipe_hit) begin
                w_green = c_ONES;
            end else begin
                w_green = c_MSB;
                w_blue  = c_ONES;
            end
        end
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_active     <= 1'b0;
            r_frame_tick <= 1'b0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
        end else begin
            r_hsync      <= (r_hc >= c_H_SYNC);
            r_vsync      <= (r_vc >= c_V_SYNC);
            r_active     <= w_visible;
            r_frame_tick <= w_tick;
            r_red        <= w_red;
            r_green      <= w_green;
            r_blue       <= w_blue;
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign active     = r_active;
    assign frame_tick = r_frame_tick;
    assign red        = r_red;
    assign green      = r_green;
    assign blue       = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_vga_scene_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scene_renderer
//  Purpose  : Self-checking bench for vga_scene_renderer on a reduced raster,
//             checked against a coordinate-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_scene_renderer;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 6;
    localparam int VA = 48, VFP = 3, VS = 2, VBP = 4;
    localparam int BX = 20, BSZ = 6, PW = 8, GAP = 10;
    localparam int HT = HS + HBP + HA + HFP;
    localparam int VT = VS + VBP + VA + VFP;
    localparam int FRAME = HT * VT;
    localparam int H0 = HS + HBP;
    localparam int V0 = VS + VBP;
    localparam int TICK_POS = (V0 + VA - 1) * HT + HT - 1;

    logic        dclk = 1'b0;
    logic        clr = 1'b1;
    logic [8:0]  bird_y = '0;
    logic [19:0] pipe_x = '1;
    logic [17:0] pipe_gap_y = '0;
    logic        game_state = 1'b1;
    logic        hsync, vsync, active, frame_tick;
    logic [2:0]  red, green, blue;
    logic [12:0] obs;

    vga_scene_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .COLOR_W(3), .BIRD_X(BX), .BIRD_SIZE(BSZ), .NUM_PIPES(2),
        .PIPE_W(PW), .GAP_H(GAP)
    ) dut (
        .dclk(dclk), .clr(clr), .bird_y(bird_y), .pipe_x(pipe_x),
        .pipe_gap_y(pipe_gap_y), .game_state(game_state),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .active(active), .frame_tick(frame_tick)
    );

    always #5 dclk = ~dclk;

    // Layout: {hsync, vsync, active, frame_tick, red, green, blue}
    assign obs = {hsync, vsync, active, frame_tick, red, green, blue};

    int          n_cmp = 0;
    int          n_err = 0;
    int          pos;
    int          sh_by;
    int          sh_px [2];
    int          sh_gy [2];
    logic [12:0] e;

    function automatic logic [12:0] model(input int p, input int by, input int px0,
                                          input int px1, input int gy0, input int gy1,
                                          input logic gs);
        int hc, vc, ax, ay;
        logic hs, vs, act, tk, bird, pipe;
        logic [8:0] rgb;
        hc   = p % HT;
        vc   = p / HT;
        ax   = hc - H0;
        ay   = vc - V0;
        hs   = !(hc < HS);
        vs   = !(vc < VS);
        act  = (ax >= 0) && (ax < HA) && (ay >= 0) && (ay < VA);
        tk   = (hc == HT - 1) && (vc == V0 + VA - 1);
        bird = (ax >= BX) && (ax < BX + BSZ) && (ay >= by) && (ay < by + BSZ);
        pipe = ((ax >= px0) && (ax < px0 + PW) && ((ay < gy0) || (ay >= gy0 + GAP))) ||
               ((ax >= px1) && (ax < px1 + PW) && ((ay < gy1) || (ay >= gy1 + GAP)));
        if (!act)      rgb = 9'o000;
        else if (bird) rgb = gs ? 9'o770 : 9'o700;
        else if (pipe) rgb = 9'o070;
        else           rgb = 9'o047;
        return {hs, vs, act, tk, rgb};
    endfunction

    task automatic model_reset();
        pos = 0;
        sh_by = 0;
        sh_px[0] = 1023; sh_px[1] = 1023;
        sh_gy[0] = 0;    sh_gy[1] = 0;
        e = '0;
    endtask

    // One clock; the model shadows pick up inputs present at the edge after a tick.
    task automatic advance();
        logic cap;
        int cby, cpx0, cpx1, cgy0, cgy1;
        cap  = e[9];
        cby  = int'(bird_y);
        cpx0 = int'(pipe_x[9:0]);   cpx1 = int'(pipe_x[19:10]);
        cgy0 = int'(pipe_gap_y[8:0]); cgy1 = int'(pipe_gap_y[17:9]);
        @(posedge dclk); #1;
        e = model(pos % FRAME, sh_by, sh_px[0], sh_px[1], sh_gy[0], sh_gy[1], game_state);
        if (cap) begin
            sh_by = cby;
            sh_px[0] = cpx0; sh_px[1] = cpx1;
            sh_gy[0] = cgy0; sh_gy[1] = cgy1;
        end
        pos++;
    endtask

    task automatic to_frame_start();
        while (pos % FRAME != 0) begin
            advance();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL sync_pixel pos=%0d got=%h want=%h", pos - 1, obs, e); end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge dclk); #1;
            n_cmp++;
            if (obs !== 13'h1800) begin n_err++; $display("FAIL reset_outputs cyc=%0d got=%h want=%h", i, obs, 13'h1800); end
        end
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_timing();
        int hs_low = 0, vs_low = 0, t1 = -1, t2 = -1, nticks = 0;
        bit hs_done = 0;
        bird_y = 9'd10;
        pipe_x = '1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL timing_pixel pos=%0d got=%h want=%h", pos - 1, obs, e); end
            if (!hs_done) begin
                if (hsync === 1'b0) hs_low++;
                else hs_done = 1;
            end
            if (i < FRAME && vsync === 1'b0) vs_low++;
            if (frame_tick === 1'b1) begin
                nticks++;
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        n_cmp++;
        if (hs_low != HS) begin n_err++; $display("FAIL hsync_width got=%0d want=%0d", hs_low, HS); end
        n_cmp++;
        if (vs_low != VS * HT) begin n_err++; $display("FAIL vsync_width got=%0d want=%0d", vs_low, VS * HT); end
        n_cmp++;
        if (t1 != TICK_POS) begin n_err++; $display("FAIL tick_position got=%0d want=%0d", t1, TICK_POS); end
        n_cmp++;
        if (t2 - t1 != FRAME) begin n_err++; $display("FAIL tick_period got=%0d want=%0d", t2 - t1, FRAME); end
        n_cmp++;
        if (nticks != 2) begin n_err++; $display("FAIL tick_count got=%0d want=2", nticks); end
    endtask

    task automatic test_scene();
        int yel = 0, grn = 0, grn_right = 0, edge0 = 0, p, ax, ay;
        to_frame_start();
        bird_y = 9'd10;
        pipe_x = {10'd60, 10'd30};
        pipe_gap_y = {9'd0, 9'd15};
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL scene_pixel pos=%0d got=%h want=%h", pos - 1, obs, e); end
            if (i >= FRAME) begin
                p  = (pos - 1) % FRAME;
                ax = p % HT - H0;
                ay = p / HT - V0;
                if (obs[8:0] == 9'o770) yel++;
                if (obs[8:0] == 9'o070) begin grn++; if (ax >= 60) grn_right++; end
                if (ax >= 0 && ax < 4 && ay >= 0 && ay < VA && obs[8:0] != 9'o047) edge0++;
            end
        end
        n_cmp++;
        if (yel != BSZ * BSZ) begin n_err++; $display("FAIL bird_area got=%0d want=%0d", yel, BSZ * BSZ); end
        n_cmp++;
        if (grn != 456) begin n_err++; $display("FAIL pipe_area got=%0d want=456", grn); end
        n_cmp++;
        if (grn_right != 152) begin n_err++; $display("FAIL pipe1_clip got=%0d want=152", grn_right); end
        n_cmp++;
        if (edge0 != 0) begin n_err++; $display("FAIL left_edge_wrap got=%0d want=0", edge0); end
    endtask

    task automatic test_midframe_bird();
        int top [2], p, ay;
        to_frame_start();
        top[0] = -1; top[1] = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL midframe_pixel pos=%0d got=%h want=%h", pos - 1, obs, e); end
            p  = (pos - 1) % FRAME;
            ay = p / HT - V0;
            if (obs[8:0] == 9'o770 && top[i / FRAME] < 0) top[i / FRAME] = ay;
            if (i == (V0 + 20) * HT) bird_y = 9'd30;
        end
        n_cmp++;
        if (top[0] != 10) begin n_err++; $display("FAIL bird_hold_frame got=%0d want=10", top[0]); end
        n_cmp++;
        if (top[1] != 30) begin n_err++; $display("FAIL bird_next_frame got=%0d want=30", top[1]); end
    endtask

    task automatic test_game_over();
        int redc = 0, yel = 0, grn = 0, sky = 0;
        to_frame_start();
        game_state = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            advance();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL gameover_pixel pos=%0d got=%h want=%h", pos - 1, obs, e); end
            if (obs[8:0] == 9'o700) redc++;
            if (obs[8:0] == 9'o770) yel++;
            if (obs[8:0] == 9'o070) grn++;
            if (obs[8:0] == 9'o047) sky++;
        end
        game_state = 1'b1;
        n_cmp++;
        if (redc != BSZ * BSZ || yel != 0) begin n_err++; $display("FAIL gameover_bird got=%0d/%0d want=%0d/0", redc, yel, BSZ * BSZ); end
        n_cmp++;
        if (grn != 456) begin n_err++; $display("FAIL gameover_pipes got=%0d want=456", grn); end
        n_cmp++;
        if (sky != HA * VA - 456 - BSZ * BSZ) begin n_err++; $display("FAIL gameover_sky got=%0d want=%0d", sky, HA * VA - 456 - BSZ * BSZ); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * FRAME; i++) begin
            advance();
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL random_pixel pos=%0d got=%h want=%h", pos - 1, obs, e); end
            if ($urandom_range(0, 299) == 0) bird_y = 9'($urandom_range(0, 60));
            if ($urandom_range(0, 299) == 0) pipe_x = {10'($urandom_range(0, 90)), 10'($urandom_range(0, 90))};
            if ($urandom_range(0, 299) == 0) pipe_gap_y = {9'($urandom_range(0, 50)), 9'($urandom_range(0, 50))};
            if ($urandom_range(0, 199) == 0) game_state = ~game_state;
        end
        game_state = 1'b1;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 1000; i++) advance();
        clr = 1'b1;
        @(posedge dclk); #1;
        n_cmp++;
        if (obs !== 13'h1800) begin n_err++; $display("FAIL midframe_reset got=%h want=%h", obs, 13'h1800); end
        clr = 1'b0;
        model_reset();
        advance();
        n_cmp++;
        if (hsync !== 1'b0) begin n_err++; $display("FAIL hsync_after_reset got=%b want=0", hsync); end
        for (int i = 0; i < FRAME; i++) begin
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL post_reset_pixel pos=%0d got=%h want=%h", pos - 1, obs, e); end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_timing();
        test_scene();
        test_midframe_bird();
        test_game_over();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
